// File: rtl/iot_event_arbiter.sv
// Round-robin front end for the active-device monitor: validates join/leave pulses per device,
// issues them one at a time, sequences monitor clears and cross-checks the returned count.
module iot_event_arbiter #(
    parameter int N_DEV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] dev_join,
    input  logic [N_DEV-1:0] dev_leave,
    input  logic             clear_req,
    input  logic [7:0]       counter_out,
    output logic             mon_rst,
    output logic             mon_on_off,
    output logic             mon_change,
    output logic [N_DEV-1:0] grant,
    output logic [N_DEV-1:0] active,
    output logic             busy,
    output logic             evt_err,
    output logic             sync_err
);

    localparam int PW = (N_DEV > 1) ? $clog2(N_DEV) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CLEAR} state_e;

    state_e           state_q, state_d;
    logic [N_DEV-1:0] active_q, active_d;
    logic [N_DEV-1:0] pend_q, pend_d;
    logic [N_DEV-1:0] dir_q, dir_d;
    logic [PW-1:0]    rr_q, rr_d;
    logic [N_DEV-1:0] grant_q, grant_d;
    logic             on_off_q, on_off_d;
    logic             change_q, change_d;
    logic             mon_rst_q, mon_rst_d;
    logic             evt_err_q, evt_err_d;
    logic             sync_err_q, sync_err_d;

    logic             can_grant;
    logic             do_grant;
    logic [PW-1:0]    gnt_idx;
    logic             eff;

    // First requesting device at or after ptr, wrapping modulo N_DEV.
    function automatic logic [PW-1:0] rr_pick(input logic [N_DEV-1:0] req, input logic [PW-1:0] ptr);
        logic [PW-1:0] sel;
        logic          found;
        int            idx;
        sel   = '0;
        found = 1'b0;
        for (int off = 0; off < N_DEV; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N_DEV) idx = idx - N_DEV;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
        return sel;
    endfunction

    function automatic logic [7:0] popcount(input logic [N_DEV-1:0] v);
        logic [7:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_DEV; i++) cnt = cnt + 8'(v[i]);
        return cnt;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch can be inferred.
        state_d    = state_q;
        active_d   = active_q;
        pend_d     = pend_q;
        dir_d      = dir_q;
        rr_d       = rr_q;
        grant_d    = '0;
        on_off_d   = 1'b0;
        change_d   = change_q;
        mon_rst_d  = 1'b0;
        evt_err_d  = 1'b0;
        sync_err_d = sync_err_q;
        do_grant   = 1'b0;
        gnt_idx    = '0;
        eff        = 1'b0;
        can_grant  = (state_q == IDLE) && !clear_req;

        if (state_q == IDLE && pend_q == '0 && !mon_rst_q && counter_out != popcount(active_q))
            sync_err_d = 1'b1;

        // An already-pending op is granted first so same-cycle events see the post-grant state.
        if (can_grant && pend_q != '0) begin
            do_grant          = 1'b1;
            gnt_idx           = rr_pick(pend_q, rr_q);
            active_d[gnt_idx] = ~active_q[gnt_idx];
            pend_d[gnt_idx]   = 1'b0;
            change_d          = dir_q[gnt_idx];
        end

        if (state_q != CLEAR && !clear_req) begin
            for (int i = 0; i < N_DEV; i++) begin
                eff = active_d[i] ^ pend_d[i];
                if (dev_join[i] && dev_leave[i]) begin
                    evt_err_d = 1'b1;
                end else if (dev_join[i] || dev_leave[i]) begin
                    if (dev_join[i] == eff) evt_err_d = 1'b1;
                    else if (pend_d[i])     pend_d[i] = 1'b0;
                    else begin
                        pend_d[i] = 1'b1;
                        dir_d[i]  = dev_join[i];
                    end
                end
            end
        end

        // Nothing was waiting: a fresh event is issued on the very next edge.
        if (can_grant && !do_grant && pend_d != '0) begin
            do_grant          = 1'b1;
            gnt_idx           = rr_pick(pend_d, rr_q);
            active_d[gnt_idx] = ~active_d[gnt_idx];
            pend_d[gnt_idx]   = 1'b0;
            change_d          = dir_d[gnt_idx];
        end

        unique case (state_q)
            IDLE:    if (clear_req) state_d = CLEAR; else if (do_grant) state_d = ISSUE;
            ISSUE:   state_d = clear_req ? CLEAR : IDLE;
            CLEAR:   state_d = IDLE;
            default: state_d = CLEAR;
        endcase

        if (do_grant) begin
            grant_d[gnt_idx] = 1'b1;
            on_off_d         = 1'b1;
            rr_d             = (int'(gnt_idx) == N_DEV - 1) ? '0 : gnt_idx + 1'b1;
        end

        if (state_d == CLEAR) begin
            mon_rst_d = 1'b1;
            active_d  = '0;
            pend_d    = '0;
            dir_d     = '0;
            rr_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= CLEAR;
            active_q   <= '0;
            pend_q     <= '0;
            dir_q      <= '0;
            rr_q       <= '0;
            grant_q    <= '0;
            on_off_q   <= 1'b0;
            change_q   <= 1'b1;
            mon_rst_q  <= 1'b1;
            evt_err_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            dir_q      <= dir_d;
            rr_q       <= rr_d;
            grant_q    <= grant_d;
            on_off_q   <= on_off_d;
            change_q   <= change_d;
            mon_rst_q  <= mon_rst_d;
            evt_err_q  <= evt_err_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign mon_rst    = mon_rst_q;
    assign mon_on_off = on_off_q;
    assign mon_change = change_q;
    assign grant      = grant_q;
    assign active     = active_q;
    assign busy       = (pend_q != '0) || (state_q != IDLE);
    assign evt_err    = evt_err_q;
    assign sync_err   = sync_err_q;

endmodule
